// File: rtl/pim_host_sequencer.sv
// Bus initiator for peri_top: loads the input buffer, issues one command, polls
// STATUS until not busy, then drains the output buffer to a valid/ready stream.
module pim_host_sequencer #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int unsigned N_IN_WORDS   = 16,
  parameter int unsigned N_OUT_WORDS  = 32,
  parameter int unsigned POLL_TIMEOUT = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  input  logic [2:0]  job_mode_i,
  input  logic [6:0]  job_row_i,
  input  logic [8:0]  job_col_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] peri_addr_o,
  output logic [31:0] peri_data_o,
  input  logic [31:0] peri_data_i
);

  localparam int unsigned IN_CW   = $clog2(N_IN_WORDS + 1);
  localparam int unsigned OUT_CW  = $clog2(N_OUT_WORDS + 1);
  localparam int unsigned POLL_CW = $clog2(POLL_TIMEOUT + 1);

  localparam logic [31:0] ADDR_INBUF  = BASE_ADDR + 32'h04;
  localparam logic [31:0] ADDR_CMD    = BASE_ADDR + 32'h08;
  localparam logic [31:0] ADDR_OUTBUF = BASE_ADDR + 32'h0C;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_POLL,
    S_POLL_WAIT,
    S_POLL_CHECK,
    S_DRAIN_REQ,
    S_DRAIN_WAIT,
    S_DRAIN_CAP,
    S_DRAIN_HOLD,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [6:0]           row_q, row_d;
  logic [8:0]           col_q, col_d;
  logic [IN_CW-1:0]     in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0]    out_cnt_q, out_cnt_d;
  logic [POLL_CW-1:0]   poll_cnt_q, poll_cnt_d;
  logic                 err_q, err_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  function automatic logic needs_in(input logic [2:0] m);
    return (m == 3'd1) || (m == 3'd3) || (m == 3'd4);
  endfunction

  function automatic logic needs_out(input logic [2:0] m);
    return (m == 3'd2) || (m == 3'd3) || (m == 3'd4);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Bus outputs are registered, so every access is decided one state ahead of
  // where it appears; read data is sampled two states after the request.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    row_d       = row_q;
    col_d       = col_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    err_d       = err_q;
    addr_d      = '0;
    data_d      = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    job_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        job_ready_o = 1'b1;
        if (job_valid_i) begin
          mode_d     = job_mode_i;
          row_d      = job_row_i;
          col_d      = job_col_i;
          err_d      = 1'b0;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          poll_cnt_d = '0;
          if (job_mode_i > 3'd4) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (needs_in(job_mode_i)) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          addr_d   = ADDR_INBUF;
          data_d   = in_data_i;
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_CW'(N_IN_WORDS - 1)) begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        addr_d  = ADDR_CMD;
        data_d  = {13'b0, mode_q, row_q, col_q};
        state_d = S_POLL;
      end

      S_POLL: begin
        addr_d     = ADDR_STATUS;
        poll_cnt_d = '0;
        state_d    = S_POLL_WAIT;
      end

      S_POLL_WAIT: begin
        state_d = S_POLL_CHECK;
      end

      S_POLL_CHECK: begin
        if (!peri_data_i[0]) begin
          if (needs_out(mode_q)) begin
            out_cnt_d = '0;
            state_d   = S_DRAIN_REQ;
          end else begin
            state_d = S_DONE;
          end
        end else if (poll_cnt_q == POLL_CW'(POLL_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          addr_d     = ADDR_STATUS;
          state_d    = S_POLL_WAIT;
        end
      end

      S_DRAIN_REQ: begin
        if (!out_valid_q) begin
          addr_d  = ADDR_OUTBUF;
          data_d  = 32'(out_cnt_q);
          state_d = S_DRAIN_WAIT;
        end
      end

      S_DRAIN_WAIT: begin
        state_d = S_DRAIN_CAP;
      end

      S_DRAIN_CAP: begin
        out_data_d  = peri_data_i;
        out_valid_d = 1'b1;
        state_d     = S_DRAIN_HOLD;
      end

      S_DRAIN_HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (out_cnt_q == OUT_CW'(N_OUT_WORDS - 1)) begin
            state_d = S_DONE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
            state_d   = S_DRAIN_REQ;
          end
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign err_o       = err_q;
  assign peri_addr_o = addr_q;
  assign peri_data_o = data_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_pim_host_sequencer.sv
// Randomized bench for pim_host_sequencer: a peri_top responder plus a job-level
// model that predicts the full bus access list, output words, done and err.
module tb_pim_host_sequencer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          T    = 8;
  localparam int          NIN  = 16;
  localparam int          NOUT = 32;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [2:0]  job_mode_i;
  logic [6:0]  job_row_i;
  logic [8:0]  job_col_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] peri_addr_o;
  logic [31:0] peri_data_o;
  logic [31:0] peri_data_i;

  always #5 clk = ~clk;

  pim_host_sequencer #(
    .BASE_ADDR   (BASE),
    .N_IN_WORDS  (NIN),
    .N_OUT_WORDS (NOUT),
    .POLL_TIMEOUT(T)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .job_valid_i(job_valid_i),
    .job_ready_o(job_ready_o),
    .job_mode_i (job_mode_i),
    .job_row_i  (job_row_i),
    .job_col_i  (job_col_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .peri_addr_o(peri_addr_o),
    .peri_data_o(peri_data_o),
    .peri_data_i(peri_data_i)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] pend_resp;
  int busy_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one job from the current negedge to completion (or to a forced reset
  // once the first drained word is presented, when abort_drain is set).
  task automatic run_job(input logic [2:0] mode, input logic [6:0] row, input logic [8:0] col,
                         input logic [31:0] wbase, input int busy_polls, input bit abort_drain);
    logic [63:0] exp_bus[$];
    logic [63:0] bus_log[$];
    logic [31:0] exp_out[$];
    logic [31:0] out_log[$];
    bit          ni, no, bad, tmo, exp_err;
    bit          accepted, held, hs, busy;
    int          acc_cyc, done_cyc, done_n, in_idx, hold_viol, n_stat;
    logic [31:0] held_data, r;

    ni  = (mode == 3'd1) || (mode == 3'd3) || (mode == 3'd4);
    no  = (mode == 3'd2) || (mode == 3'd3) || (mode == 3'd4);
    bad = mode > 3'd4;
    tmo = busy_polls >= T;
    if (!bad) begin
      if (ni) for (int i = 0; i < NIN; i++) exp_bus.push_back({BASE + 32'h04, wbase + 32'(i)});
      exp_bus.push_back({BASE + 32'h08, (32'(mode) << 16) | (32'(row) << 9) | 32'(col)});
      n_stat = tmo ? T : busy_polls + 1;
      for (int i = 0; i < n_stat; i++) exp_bus.push_back({BASE + 32'h10, 32'h0});
      if (no && !tmo) begin
        for (int i = 0; i < NOUT; i++) begin
          exp_bus.push_back({BASE + 32'h0C, 32'(i)});
          exp_out.push_back(32'hA5A5_0000 + 32'(i));
        end
      end
    end
    exp_err = bad || (tmo && !bad);

    busy_left = busy_polls;
    accepted  = 0;
    acc_cyc   = 0;
    done_cyc  = 0;
    done_n    = 0;
    in_idx    = 0;
    hold_viol = 0;
    held      = 0;
    held_data = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      // peri_top responder: read data is visible for the cycle after the address
      peri_data_i = pend_resp;
      r = $urandom;
      if (peri_addr_o == BASE + 32'h10) begin
        busy = busy_left > 0;
        if (busy) busy_left--;
        pend_resp = {r[31:1], busy};
      end else if (peri_addr_o == BASE + 32'h0C) begin
        pend_resp = 32'hA5A5_0000 + peri_data_o;
      end else begin
        pend_resp = r;
      end
      if (peri_addr_o != 32'h0) bus_log.push_back({peri_addr_o, peri_data_o});

      if (accepted && cyc == acc_cyc + 1) check("err_on_accept", 32'(err_o), 32'(bad));
      if (done_o) begin
        done_n++;
        if (done_n == 1) begin
          done_cyc = cyc;
          check("err_at_done", 32'(err_o), 32'(exp_err));
        end
      end
      if (held && (!out_valid_o || out_data_o !== held_data)) hold_viol++;

      if (abort_drain && out_valid_o) begin
        rst_ni = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid_o), 32'h0);
        check("rst_peri_addr", peri_addr_o, 32'h0);
        check("rst_job_ready", 32'(job_ready_o), 32'h1);
        check("rst_done", 32'(done_o), 32'h0);
        job_valid_i = 0;
        in_valid_i  = 0;
        out_ready_i = 0;
        @(negedge clk);
        check("rst_no_done", 32'(done_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);
        return;
      end

      if (done_n > 0 && cyc >= done_cyc + 3) break;

      if (!accepted) begin
        job_valid_i = 1'b1;
        job_mode_i  = mode;
        job_row_i   = row;
        job_col_i   = col;
        if (job_ready_o) begin
          accepted = 1;
          acc_cyc  = cyc;
        end
      end else begin
        job_valid_i = (!job_ready_o && done_n == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        job_mode_i  = 3'($urandom);
        job_row_i   = 7'($urandom);
        job_col_i   = 9'($urandom);
      end

      if (in_ready_o && ni && in_idx < NIN) begin
        in_valid_i = $urandom_range(0, 2) != 0;
        in_data_i  = wbase + 32'(in_idx);
        if (in_valid_i) in_idx++;
      end else if (!in_ready_o) begin
        in_valid_i = 1'($urandom_range(0, 1));
        in_data_i  = $urandom;
      end else begin
        in_valid_i = 1'b0;
      end

      out_ready_i = 1'($urandom_range(0, 1));
      hs = out_valid_o && out_ready_i;
      if (hs) out_log.push_back(out_data_o);
      held      = out_valid_o && !hs;
      held_data = out_data_o;

      @(negedge clk);
    end

    job_valid_i = 0;
    in_valid_i  = 0;
    out_ready_i = 0;
    check("done_count", 32'(done_n), 32'h1);
    if (bad && done_n > 0) check("done_latency", 32'(done_cyc - acc_cyc), 32'h1);
    check("bus_len", 32'(bus_log.size()), 32'(exp_bus.size()));
    for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
      check($sformatf("bus_addr[%0d]", i), bus_log[i][63:32], exp_bus[i][63:32]);
      check($sformatf("bus_data[%0d]", i), bus_log[i][31:0], exp_bus[i][31:0]);
    end
    check("out_len", 32'(out_log.size()), 32'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && i < out_log.size(); i++)
      check($sformatf("out_word[%0d]", i), out_log[i], exp_out[i]);
    check("hold_stable", 32'(hold_viol), 32'h0);
    check("err_sticky", 32'(err_o), 32'(exp_err));
    check("idle_ready", 32'(job_ready_o), 32'h1);
  endtask

  initial begin
    rst_ni      = 1'b0;
    job_valid_i = 0;
    job_mode_i  = '0;
    job_row_i   = '0;
    job_col_i   = '0;
    in_valid_i  = 0;
    in_data_i   = '0;
    out_ready_i = 0;
    peri_data_i = '0;
    pend_resp   = '0;
    busy_left   = 0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", 32'(job_ready_o), 32'h1);
    check("rst_in_ready", 32'(in_ready_o), 32'h0);
    check("rst_out_valid", 32'(out_valid_o), 32'h0);
    check("rst_out_data", out_data_o, 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_peri_addr", peri_addr_o, 32'h0);
    check("rst_peri_data", peri_data_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);

    run_job(3'd0, 7'd5, 9'h1A, 32'h0, 3, 0);
    run_job(3'd1, 7'($urandom), 9'($urandom), 32'h0, 1, 0);
    run_job(3'd2, 7'($urandom), 9'($urandom), 32'h0, 2, 0);
    run_job(3'd3, 7'($urandom), 9'($urandom), $urandom, 100, 0);
    run_job(3'd6, 7'($urandom), 9'($urandom), 32'h0, 0, 0);
    run_job(3'd4, 7'($urandom), 9'($urandom), $urandom, 0, 0);
    run_job(3'd2, 7'($urandom), 9'($urandom), 32'h0, 0, 1);
    run_job(3'd4, 7'($urandom), 9'($urandom), $urandom, T - 1, 0);
    for (int j = 0; j < 12; j++)
      run_job(3'($urandom), 7'($urandom), 9'($urandom), $urandom, $urandom_range(0, T + 1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
